// File: rtl/mul_ci_pkg.sv
// Shared opcodes, FSM state type and configuration check for the multicycle
// custom-instruction multiplier.
package mul_ci_pkg;

  localparam logic [2:0] OP_MULLO = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_MULHS = 3'd2;
  localparam logic [2:0] OP_MAC   = 3'd3;
  localparam logic [2:0] OP_RDHI  = 3'd4;
  localparam logic [2:0] OP_CLR   = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic bit mul_ci_cfg_ok(int unsigned width, int unsigned step);
    return (width >= 8) && (width % 2 == 0) &&
           (step == 1 || step == 2 || step == 4) && (width % step == 0);
  endfunction

endpackage

// File: rtl/mul_ci_step.sv
// Combinational shift-add step: adds a * bs to the running product high half and
// splits the sum into the new high half and the bits shifted out below it.
module mul_ci_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [STEP-1:0]  bs,
  input  logic [WIDTH-1:0] phi,
  output logic [WIDTH-1:0] phi_new,
  output logic [STEP-1:0]  lo_out
);

  // Cannot overflow: phi + a*bs < 2^WIDTH * 2^STEP.
  logic [WIDTH+STEP-1:0] sum;

  assign sum     = (WIDTH+STEP)'(phi) + (WIDTH+STEP)'(a) * (WIDTH+STEP)'(bs);
  assign phi_new = sum[WIDTH+STEP-1:STEP];
  assign lo_out  = sum[STEP-1:0];

endmodule

// File: rtl/mul_ci_seq.sv
// Multicycle shift-add multiplier on the Nios II custom-instruction port.
// Define MUL_CI_MAC_EN to add the 2*WIDTH-bit multiply-accumulate register.
module mul_ci_seq
  import mul_ci_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [2:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH / STEP + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / STEP);

  if (!mul_ci_cfg_ok(WIDTH, STEP)) begin : g_bad_cfg
    $error("mul_ci_seq: illegal WIDTH/STEP combination");
  end

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, bsh_q;
  logic [2:0]         n_q;
  logic [2*WIDTH-1:0] prod_q, prod_next;
  logic [WIDTH-1:0]   phi_new;
  logic [STEP-1:0]    lo_out;
  logic [WIDTH-1:0]   mulhs, res_d;

  mul_ci_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .a       (a_q),
    .bs      (bsh_q[STEP-1:0]),
    .phi     (prod_q[2*WIDTH-1:WIDTH]),
    .phi_new (phi_new),
    .lo_out  (lo_out)
  );

  // Retired multiplier bits enter just below the high half; the low half shifts right.
  assign prod_next = {phi_new, lo_out, prod_q[WIDTH-1:STEP]};

  // Two's-complement correction of the unsigned high half.
  assign mulhs = prod_q[2*WIDTH-1:WIDTH]
               - (a_q[WIDTH-1] ? b_q : '0)
               - (b_q[WIDTH-1] ? a_q : '0);

`ifdef MUL_CI_MAC_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
`endif

  always_comb begin
    res_d = '0;
`ifdef MUL_CI_MAC_EN
    acc_d = acc_q;
`endif
    case (n_q)
      OP_MULLO: res_d = prod_q[WIDTH-1:0];
      OP_MULHU: res_d = prod_q[2*WIDTH-1:WIDTH];
      OP_MULHS: res_d = mulhs;
`ifdef MUL_CI_MAC_EN
      OP_MAC: begin
        acc_d = acc_q + prod_q;
        res_d = acc_d[WIDTH-1:0];
      end
      OP_RDHI: res_d = acc_q[2*WIDTH-1:WIDTH];
      OP_CLR:  acc_d = '0;
`endif
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bsh_q   <= '0;
      n_q     <= '0;
      prod_q  <= '0;
      result  <= '0;
      done    <= 1'b0;
`ifdef MUL_CI_MAC_EN
      acc_q   <= '0;
`endif
    end else if (clk_en) begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= dataa;
            b_q     <= datab;
            bsh_q   <= datab;
            n_q     <= n;
            prod_q  <= '0;
            cnt_q   <= CNT_INIT;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          prod_q <= prod_next;
          bsh_q  <= bsh_q >> STEP;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= StDone;
        end
        StDone: begin
          result  <= res_d;
          done    <= 1'b1;
`ifdef MUL_CI_MAC_EN
          acc_q   <= acc_d;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ci_seq.sv
// Self-checking bench for mul_ci_seq: directed cases plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_mul_ci_seq;

  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [2:0]  n;
  logic [31:0] dataa, datab, result;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl_acc = '0;

  mul_ci_seq #(.WIDTH(32), .STEP(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result of one completed op, updating the model accumulator.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r);
    logic [63:0] p, ps;
    p  = {32'b0, a} * {32'b0, b};
    ps = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    r  = '0;
    case (op)
      3'd0: r = p[31:0];
      3'd1: r = p[63:32];
      3'd2: r = ps[63:32];
`ifdef MUL_CI_MAC_EN
      3'd3: begin mdl_acc = mdl_acc + p; r = mdl_acc[31:0]; end
      3'd4: r = mdl_acc[63:32];
      3'd5: begin mdl_acc = '0; r = '0; end
`endif
      default: r = '0;
    endcase
  endtask

  // Issues one op, optionally stalls clk_en and fires an ignored second start.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len, input bit restart,
                        output logic [31:0] res, output int lat);
    clk_en = 1'b1;
    start  = 1'b1;
    n      = op;
    dataa  = a;
    datab  = b;
    tick();
    start = 1'b0;
    check("done_low_after_start", 64'(done), 64'd0);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      clk_en = !(lat >= stall_at && lat < stall_at + stall_len);
      if (restart && lat == 5) begin
        start = 1'b1;
        n     = 3'($urandom_range(0, 7));
        dataa = $urandom;
        datab = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
      if (done) break;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    res    = result;
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] r, m;
    int lat;
    run_op(op, a, b, 0, 0, 1'b0, r, lat);
    model(op, a, b, m);
    check({tag, "_res"}, 64'(r), 64'(exp));
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
  endtask

  initial begin
    logic [31:0] r, m, a, b;
    logic [2:0]  op;
    int lat, sa, sl, hits;

    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_result", 64'(result), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    directed("mullo_332x22", 3'd0, 32'd332, 32'd22, 32'd7304);
    directed("mullo_2x23", 3'd0, 32'd2, 32'd23, 32'd46);
    directed("mulhu_ones", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("mullo_ones", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    directed("mulhs_m1m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    directed("mulhs_min_x2", 3'd2, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
    directed("reserved6", 3'd6, 32'd7, 32'd9, 32'd0);
    directed("reserved7", 3'd7, 32'hFFFF_FFFF, 32'd3, 32'd0);
`ifdef MUL_CI_MAC_EN
    directed("clr0", 3'd5, 32'd0, 32'd0, 32'd0);
    directed("mac_3x4", 3'd3, 32'd3, 32'd4, 32'd12);
    directed("mac_5x6", 3'd3, 32'd5, 32'd6, 32'd42);
    directed("rdhi", 3'd4, 32'd0, 32'd0, 32'd0);
    directed("clr1", 3'd5, 32'd0, 32'd0, 32'd0);
    directed("mac_1x1", 3'd3, 32'd1, 32'd1, 32'd1);
`else
    directed("nomac3", 3'd3, 32'd3, 32'd4, 32'd0);
    directed("nomac4", 3'd4, 32'd3, 32'd4, 32'd0);
`endif

    // Stall: three clk_en-low cycles during BUSY stretch latency by three.
    run_op(3'd0, 32'd1234, 32'd5678, 4, 3, 1'b0, r, lat);
    model(3'd0, 32'd1234, 32'd5678, m);
    check("stall_res", 64'(r), 64'(32'd7006652));
    check("stall_lat", 64'(lat), 64'(LAT + 3));

    // A second start mid-BUSY must not disturb the op in flight.
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1'b1, r, lat);
    model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, m);
    check("restart_res", 64'(r), 64'(m));
    check("restart_lat", 64'(lat), 64'(LAT));
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) hits++;
    end
    check("restart_no_extra_done", 64'(hits), 64'd0);

    // Reset at BUSY cycle 5 aborts without a done.
    start = 1'b1; n = 3'd0; dataa = 32'd99; datab = 32'd99;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl_acc = '0;
    check("abort_result", 64'(result), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) hits++;
    end
    check("abort_no_done", 64'(hits), 64'd0);
    directed("after_abort", 3'd0, 32'd332, 32'd22, 32'd7304);

    // Randomized ops, issued back-to-back, some with stalls.
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h8000_0000 | $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      sa = $urandom_range(1, 8);
      sl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      run_op(op, a, b, sa, sl, 1'b0, r, lat);
      model(op, a, b, m);
      check($sformatf("rand%0d_n%0d_res", t, op), 64'(r), 64'(m));
      check($sformatf("rand%0d_lat", t), 64'(lat), 64'(LAT + sl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
